m68k_bus_target: RTL and testbench

Responder-side 68000 asynchronous bus interface that sits between the fx68k core's bus (AS/UDS/LDS/RW/DTACK) and a simple synchronous request/acknowledge device port. It lets slow or variable-latency peripherals (SDRAM, flash, OLED frame memory) sit on the CPU bus without the fixed one-cycle DTACK shortcut. It latches address, strobes and write data, runs the device handshake, and returns DTACK once the device responds. An optional watchdog raises BERR if the device never responds.

---
 rtl/m68k_bus_pkg.sv | 15 +
 rtl/m68k_bus_target.sv | 156 +++++++++++++++
 tb/tb_m68k_bus_target.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for 68000-side bus bridges.
// State encodings and CPU direction constants.
package m68k_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        ERROR  = 2'd3
    } bus_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/m68k_bus_target.sv
// 68000 bus responder bridging AS/UDS/LDS/DTACK to a req/ack device port.
// Optional watchdog converts a silent device into BERR.
module m68k_bus_target
    import m68k_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  as_n,
    input  logic                  uds_n,
    input  logic                  lds_n,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           din,
    output logic [15:0]           dout,
    output logic                  dtack_n,
    output logic                  berr_n,
    output logic                  dev_req,
    output logic                  dev_we,
    output logic [1:0]            dev_be,
    output logic [ADDR_WIDTH-1:0] dev_addr,
    output logic [15:0]           dev_wdata,
    input  logic [15:0]           dev_rdata,
    input  logic                  dev_ack
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    bus_state_t state_q, state_d;
    logic [15:0]           dout_q, dout_d;
    logic                  dtack_n_q, dtack_n_d;
    logic                  berr_n_q, berr_n_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [1:0]            be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic start;
    logic tmo;

    assign start = cs & ~as_n & (~uds_n | ~lds_n);
    assign tmo   = (TIMEOUT != 0) && (cnt_q == TMO_VAL) && !dev_ack;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dout_q    <= '0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: device ack beats the watchdog, CPU abort skips DTACK
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ACCESS;
            end
            ACCESS: begin
                if (dev_ack) begin
                    state_d = as_n ? IDLE : HOLD;
                end else if (tmo) begin
                    state_d = as_n ? IDLE : ERROR;
                end
            end
            HOLD: begin
                if (as_n) state_d = IDLE;
            end
            ERROR: begin
                if (as_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath updates for each state
    always_comb begin
        dout_d    = dout_q;
        dtack_n_d = dtack_n_q;
        berr_n_d  = berr_n_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    wdata_d = din;
                    be_d    = {~uds_n, ~lds_n};
                    we_d    = (rw == RW_WRITE);
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (dev_ack) begin
                    req_d = 1'b0;
                    if (!as_n) begin
                        if (!we_q) dout_d = dev_rdata;
                        dtack_n_d = 1'b0;
                    end
                end else if (tmo) begin
                    req_d = 1'b0;
                    if (!as_n) berr_n_d = 1'b0;
                end
            end
            HOLD: begin
                if (as_n) dtack_n_d = 1'b1;
            end
            ERROR: begin
                if (as_n) berr_n_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign dout      = dout_q;
    assign dtack_n   = dtack_n_q;
    assign berr_n    = berr_n_q;
    assign dev_req   = req_q;
    assign dev_we    = we_q;
    assign dev_be    = be_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Scoreboard bench for m68k_bus_target: stimulus queues expected
// output edges, a negedge monitor pops and compares them.
module tb_m68k_bus_target;

    localparam int AW = 11;

    localparam int EV_REQ_RISE   = 0;
    localparam int EV_REQ_FALL   = 1;
    localparam int EV_DTACK_FALL = 2;
    localparam int EV_DTACK_RISE = 3;
    localparam int EV_BERR_FALL  = 4;
    localparam int EV_BERR_RISE  = 5;

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] dout;
        logic        we;
        logic [1:0]  be;
        logic [AW-1:0] addr;
        logic [15:0] wdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs;
    logic          as_n;
    logic          uds_n;
    logic          lds_n;
    logic          rw;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [15:0]   dout;
    logic          dtack_n;
    logic          berr_n;
    logic          dev_req;
    logic          dev_we;
    logic [1:0]    dev_be;
    logic [AW-1:0] dev_addr;
    logic [15:0]   dev_wdata;
    logic [15:0]   dev_rdata;
    logic          dev_ack;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    logic p_req, p_dtack_n, p_berr_n;

    m68k_bus_target #(.ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .as_n      (as_n),
        .uds_n     (uds_n),
        .lds_n     (lds_n),
        .rw        (rw),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .dtack_n   (dtack_n),
        .berr_n    (berr_n),
        .dev_req   (dev_req),
        .dev_we    (dev_we),
        .dev_be    (dev_be),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic push(input int kind, input int c,
                        input logic [15:0] d = 16'h0,
                        input logic we = 1'b0,
                        input logic [1:0] be = 2'b00,
                        input logic [AW-1:0] a = '0,
                        input logic [15:0] wd = 16'h0);
        exp_t e;
        e.kind = kind; e.cyc = c; e.dout = d;
        e.we = we; e.be = be; e.addr = a; e.wdata = wd;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: kind %0d at cyc %0d, none expected",
                     kind, cyc);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            miscompares++;
            $display("FAIL event_timing: got kind %0d cyc %0d, want kind %0d cyc %0d",
                     kind, cyc, e.kind, e.cyc);
        end
        if (kind == EV_REQ_RISE) begin
            vectors++;
            if (dev_we !== e.we || dev_be !== e.be ||
                dev_addr !== e.addr || dev_wdata !== e.wdata) begin
                miscompares++;
                $display("FAIL req_fields: got we=%b be=%b addr=%h wd=%h, want we=%b be=%b addr=%h wd=%h",
                         dev_we, dev_be, dev_addr, dev_wdata,
                         e.we, e.be, e.addr, e.wdata);
            end
        end
        if (kind == EV_DTACK_FALL) begin
            vectors++;
            if (dout !== e.dout) begin
                miscompares++;
                $display("FAIL dtack_dout: got %h, want %h", dout, e.dout);
            end
        end
    endtask

    // Monitor: every output edge must match the head of the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (dev_req === 1'b1 && p_req === 1'b0) check_ev(EV_REQ_RISE);
            if (dev_req === 1'b0 && p_req === 1'b1) check_ev(EV_REQ_FALL);
            if (dtack_n === 1'b0 && p_dtack_n === 1'b1) check_ev(EV_DTACK_FALL);
            if (dtack_n === 1'b1 && p_dtack_n === 1'b0) check_ev(EV_DTACK_RISE);
            if (berr_n === 1'b0 && p_berr_n === 1'b1) check_ev(EV_BERR_FALL);
            if (berr_n === 1'b1 && p_berr_n === 1'b0) check_ev(EV_BERR_RISE);
        end
        p_req     <= dev_req;
        p_dtack_n <= dtack_n;
        p_berr_n  <= berr_n;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic bus_idle();
        cs = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    endtask

    task automatic bus_start(input logic r, input logic u, input logic l,
                             input logic [AW-1:0] a, input logic [15:0] d);
        cs = 1'b1; as_n = 1'b0; uds_n = u; lds_n = l; rw = r;
        addr = a; din = d;
    endtask

    initial begin
        int s;
        rst_n = 1'b0;
        bus_idle();
        addr = '0; din = '0; dev_rdata = '0; dev_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_dtack_n", 32'(dtack_n), 32'h1);
        chk("rst_berr_n", 32'(berr_n), 32'h1);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dev_bus", {dev_req, dev_we, dev_be, 5'b0, dev_addr},
            32'h0);
        chk("rst_wdata", 32'(dev_wdata), 32'h0);
        mon_en = 1'b1;
        @(negedge clk);

        // Read, device acks 3 cycles after dev_req
        s = cyc;
        bus_start(1'b1, 1'b0, 1'b0, 11'h155, 16'h0000);
        push(EV_REQ_RISE, s + 1, 16'h0, 1'b0, 2'b11, 11'h155, 16'h0000);
        push(EV_REQ_FALL, s + 5);
        push(EV_DTACK_FALL, s + 5, 16'hBEEF);
        push(EV_DTACK_RISE, s + 7);
        to_cyc(s + 4);
        dev_ack = 1'b1; dev_rdata = 16'hBEEF;
        to_cyc(s + 5);
        dev_ack = 1'b0; dev_rdata = 16'h0;
        to_cyc(s + 6);
        bus_idle();
        to_cyc(s + 9);

        // Write, lower byte only, device acks at minimum latency
        s = cyc;
        bus_start(1'b0, 1'b1, 1'b0, 11'h012, 16'h1234);
        push(EV_REQ_RISE, s + 1, 16'h0, 1'b1, 2'b01, 11'h012, 16'h1234);
        push(EV_REQ_FALL, s + 2);
        push(EV_DTACK_FALL, s + 2, 16'hBEEF);
        push(EV_DTACK_RISE, s + 4);
        to_cyc(s + 1);
        dev_ack = 1'b1; dev_rdata = 16'hDEAD;
        to_cyc(s + 2);
        dev_ack = 1'b0; dev_rdata = 16'h0;
        to_cyc(s + 3);
        bus_idle();
        to_cyc(s + 6);

        // Watchdog: device never acks, late ack ignored
        s = cyc;
        bus_start(1'b1, 1'b0, 1'b1, 11'h3FF, 16'h00FF);
        push(EV_REQ_RISE, s + 1, 16'h0, 1'b0, 2'b10, 11'h3FF, 16'h00FF);
        push(EV_REQ_FALL, s + 10);
        push(EV_BERR_FALL, s + 10);
        push(EV_BERR_RISE, s + 13);
        to_cyc(s + 12);
        bus_idle();
        to_cyc(s + 14);
        dev_ack = 1'b1; dev_rdata = 16'h7777;
        to_cyc(s + 15);
        dev_ack = 1'b0; dev_rdata = 16'h0;
        to_cyc(s + 17);
        chk("tmo_dout_kept", 32'(dout), 32'h0000BEEF);

        // CPU abort during ACCESS, then a normal read
        s = cyc;
        bus_start(1'b1, 1'b0, 1'b0, 11'h0AA, 16'h0000);
        push(EV_REQ_RISE, s + 1, 16'h0, 1'b0, 2'b11, 11'h0AA, 16'h0000);
        push(EV_REQ_FALL, s + 5);
        to_cyc(s + 2);
        bus_idle();
        to_cyc(s + 4);
        dev_ack = 1'b1; dev_rdata = 16'h5555;
        to_cyc(s + 5);
        dev_ack = 1'b0; dev_rdata = 16'h0;
        to_cyc(s + 6);
        chk("abort_dout_kept", 32'(dout), 32'h0000BEEF);
        chk("abort_dtack_n", 32'(dtack_n), 32'h1);
        bus_start(1'b1, 1'b0, 1'b0, 11'h077, 16'h0000);
        push(EV_REQ_RISE, s + 7, 16'h0, 1'b0, 2'b11, 11'h077, 16'h0000);
        push(EV_REQ_FALL, s + 8);
        push(EV_DTACK_FALL, s + 8, 16'h0F0F);
        push(EV_DTACK_RISE, s + 10);
        to_cyc(s + 7);
        dev_ack = 1'b1; dev_rdata = 16'h0F0F;
        to_cyc(s + 8);
        dev_ack = 1'b0; dev_rdata = 16'h0;
        to_cyc(s + 9);
        bus_idle();
        to_cyc(s + 12);

        // Reset while in HOLD
        s = cyc;
        bus_start(1'b1, 1'b0, 1'b0, 11'h001, 16'h0000);
        push(EV_REQ_RISE, s + 1, 16'h0, 1'b0, 2'b11, 11'h001, 16'h0000);
        push(EV_REQ_FALL, s + 2);
        push(EV_DTACK_FALL, s + 2, 16'hA5A5);
        push(EV_DTACK_RISE, s + 4);
        to_cyc(s + 1);
        dev_ack = 1'b1; dev_rdata = 16'hA5A5;
        to_cyc(s + 2);
        dev_ack = 1'b0; dev_rdata = 16'h0;
        to_cyc(s + 3);
        rst_n = 1'b0;
        to_cyc(s + 4);
        chk("hold_rst_dout", 32'(dout), 32'h0);
        chk("hold_rst_dev", {dev_req, dev_be, 2'b0, dev_addr}, 32'h0);
        rst_n = 1'b1;
        bus_idle();
        to_cyc(s + 6);

        // Reset drops an outstanding request without ack
        s = cyc;
        bus_start(1'b0, 1'b0, 1'b0, 11'h100, 16'hCAFE);
        push(EV_REQ_RISE, s + 1, 16'h0, 1'b1, 2'b11, 11'h100, 16'hCAFE);
        push(EV_REQ_FALL, s + 3);
        to_cyc(s + 2);
        rst_n = 1'b0;
        to_cyc(s + 3);
        rst_n = 1'b1;
        bus_idle();
        to_cyc(s + 5);

        // Not selected: no request, no acknowledge
        s = cyc;
        cs = 1'b0; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1;
        addr = 11'h222;
        to_cyc(s + 4);
        chk("nocs_quiet", {dev_req, dtack_n, berr_n}, 32'h3);

        // Normal read after all of the above
        s = cyc;
        bus_start(1'b1, 1'b0, 1'b0, 11'h2AA, 16'h0000);
        push(EV_REQ_RISE, s + 1, 16'h0, 1'b0, 2'b11, 11'h2AA, 16'h0000);
        push(EV_REQ_FALL, s + 3);
        push(EV_DTACK_FALL, s + 3, 16'h1357);
        push(EV_DTACK_RISE, s + 5);
        to_cyc(s + 2);
        dev_ack = 1'b1; dev_rdata = 16'h1357;
        to_cyc(s + 3);
        dev_ack = 1'b0; dev_rdata = 16'h0;
        to_cyc(s + 4);
        bus_idle();
        to_cyc(s + 8);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
